rv32_fetch_stage: RTL and testbench
===================================

RV32_FETCH_STAGE -- requirements
Module: rv32_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stop  input  1  global pipeline freeze; all fetch state and outputs hold.
REQ-005 SHALL have port stall  input  1  decode hazard stall; output buffer holds.
REQ-006 SHALL have port branch_taken  input  1  redirect request from exec.
REQ-007 SHALL have port branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-008 SHALL have port imem_req  output  1  instruction read request, held until granted.
REQ-009 SHALL have port imem_addr  output  32  word-aligned request address, stable while imem_req=1.
REQ-010 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  read data valid; at most one outstanding request.
REQ-012 SHALL have port imem_rdata  input  32  returned instruction.
REQ-013 SHALL have port fetch_decode_buff  output  fetch_decode_buffer_t  registered pc and generate_nop to decode.
REQ-014 SHALL have port instr  output  rv_instr_t  registered instruction matching fetch_decode_buff.pc.

Function
REQ-015 SHALL implement states ST_REQ (drive request), ST_WAIT (one request outstanding), ST_DROP (discard response of a squashed request).
REQ-016 SHALL hold fetch_pc (next address) and req_pc (outstanding address); imem_addr = fetch_pc.
REQ-017 SHALL assert imem_req in ST_REQ, and in ST_WAIT in the cycle imem_rvalid=1 while the instruction holding entry is free or being consumed.
REQ-018 SHALL, on imem_gnt, set req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, no overflow flag), state<=ST_WAIT.
REQ-019 SHALL, on imem_rvalid in ST_WAIT, write imem_rdata/req_pc into the single-entry holding register; if it is full and not consumed, request issue SHALL pause.
REQ-020 SHALL advance the output registers only when stop=0 and stall=0: if the holding entry is valid, load pc/instr with generate_nop=0 and free the entry; otherwise load generate_nop=1 with pc unchanged.
REQ-021 SHALL, with stall=1 and stop=0, hold fetch_decode_buff/instr unchanged while memory traffic continues up to the holding-entry limit.
REQ-022 SHALL, on branch_taken with stop=0, set fetch_pc<=branch_target, clear the holding entry, load generate_nop=1, and go ST_DROP if a request is outstanding without rvalid this cycle, else ST_REQ; branch_taken overrides stall.
REQ-023 SHALL, in ST_DROP, ignore imem_rdata, deassert imem_req, and go ST_REQ on imem_rvalid.
REQ-024 SHALL, on branch_taken with stop=1, latch a pending redirect (latest target wins) and apply it per REQ-022 in the first cycle with stop=0.
REQ-025 SHALL, with stop=1, freeze state, fetch_pc, holding entry and outputs, except that a rvalid arriving for an outstanding request is captured into the holding entry.
REQ-026 SHALL never present a squashed or duplicate instruction with generate_nop=0.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, set state<=ST_REQ, fetch_pc<=RESET_PC, req_pc<=RESET_PC, clear holding entry and pending redirect, fetch_decode_buff.pc<=RESET_PC, generate_nop<=1, instr<=RV_NOP.
REQ-028 SHALL hold imem_req=0 during the reset cycle; reset mid-transaction SHALL go ST_DROP if a grant is outstanding, else ST_REQ.
REQ-029 SHALL give reset priority over stop, stall and branch_taken.

Structure
REQ-030 SHALL place fetch_state_t enum and the default RESET_PC constant in rv32_types; fetch_decode_buffer_t stays there unchanged.
REQ-031 SHALL implement the holding entry as sub-module rv32_fetch_instr_buffer (valid, pc, instr; write, consume, flush).

Verification
REQ-032 Reset, then memory with gnt=1 and 1-cycle rvalid -> pc sequence 0x0,0x4,0x8 at one instruction per cycle after the first, generate_nop=0.
REQ-033 stall=1 for 3 cycles at pc=0x8 -> output holds 0x8 for 3 cycles, then 0xC with no instruction lost or duplicated.
REQ-034 branch_taken with target 0x103 while 0x10 is outstanding -> 0x10 data discarded, one generate_nop=1 bubble, next valid pc=0x100.
REQ-035 branch_taken during stop=1 with target 0x200, stop released 2 cycles later -> next valid pc=0x200, nothing from the old path.
REQ-036 reset asserted while a request is granted and rvalid returns the following cycle -> that response is dropped, first valid pc=RESET_PC.
REQ-037 gnt delayed 4 cycles -> imem_addr stable and imem_req held high throughout, generate_nop=1 until data returns.

Source files
------------

// File: rtl/rv32_types.sv
// Shared types and constants for the RV32 fetch stage: the decode handoff
// record, the fetch state encoding and the default reset vector.
package rv32_types;

    typedef logic [31:0] rv_instr_t;

    // addi x0, x0, 0
    localparam rv_instr_t RV_NOP = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        generate_nop;
    } fetch_decode_buffer_t;

    // ST_REQ  : a request may be driven to instruction memory
    // ST_WAIT : exactly one request is outstanding
    // ST_DROP : one request is outstanding but its response belongs to a squashed path
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; the low two bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32_fetch_instr_buffer.sv
// Single-entry holding register between the instruction memory response and
// the fetch output registers. Flush and reset empty it; a write in the same
// cycle as a consume replaces the entry so it stays full.
module rv32_fetch_instr_buffer
    import rv32_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_write,
    input  logic [31:0] i_pc,
    input  rv_instr_t   i_instr,
    input  logic        i_consume,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output rv_instr_t   o_instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    rv_instr_t   r_instr;

    // Entry update: flush beats write, write beats consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= RV_NOP;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_write) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch stage: issues one word-aligned request at a time to
// instruction memory, parks the response in a single holding entry, and feeds
// decode through registered pc/instr outputs. Handles decode stalls, global
// freeze, branch redirects (including redirects raised while frozen) and
// squashing of responses that belong to an abandoned path.
module rv32_fetch_stage
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stop,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output fetch_decode_buffer_t fetch_decode_buff,
    output rv_instr_t            instr
);

    fetch_state_t         r_state;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_req_pc;
    logic                 r_pend_valid;
    logic [31:0]          r_pend_target;
    fetch_decode_buffer_t r_out;
    rv_instr_t            r_instr;

    logic        w_buf_valid;
    logic [31:0] w_buf_pc;
    rv_instr_t   w_buf_instr;

    logic        w_redirect;
    logic [31:0] w_redirect_target;
    logic        w_consume;
    logic        w_room;
    logic        w_resp;
    logic        w_buf_write;
    logic        w_issue;
    logic        w_grant;
    logic        w_outstanding;

    // A redirect is applied only while the pipeline runs; a live branch is
    // newer than any redirect latched during a freeze, so it wins.
    assign w_redirect        = !stop && (branch_taken || r_pend_valid);
    assign w_redirect_target = align_word(branch_taken ? branch_target : r_pend_target);

    // The output registers drain the holding entry whenever decode accepts.
    assign w_consume = !reset && !stop && !stall && !w_redirect && w_buf_valid;

    // The entry can take a new word if it is empty or being drained this cycle.
    assign w_room = !w_buf_valid || w_consume;

    // A response in ST_WAIT is for the live path; in ST_DROP it is ignored.
    assign w_resp      = imem_rvalid && (r_state == ST_WAIT);
    assign w_buf_write = !reset && !w_redirect && w_resp && w_room;

    // New requests go out from ST_REQ, or back-to-back with a response, but
    // only when there is room for the word they will bring back.
    assign w_issue = !reset && !stop && !w_redirect && w_room &&
                     ((r_state == ST_REQ) || w_resp);
    assign w_grant = w_issue && imem_gnt;

    // A request still owed a response after this cycle must be drained in ST_DROP.
    assign w_outstanding = ((r_state == ST_WAIT) || (r_state == ST_DROP)) && !imem_rvalid;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;

    rv32_fetch_instr_buffer u_instr_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_write   (w_buf_write),
        .i_pc      (r_req_pc),
        .i_instr   (imem_rdata),
        .i_consume (w_consume),
        .i_flush   (w_redirect),
        .o_valid   (w_buf_valid),
        .o_pc      (w_buf_pc),
        .o_instr   (w_buf_instr)
    );

    // Request sequencing. If a response arrives while the entry is full and
    // decode is not draining it, the word is discarded and its address is
    // refetched later, so nothing is lost and nothing is duplicated.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= w_outstanding ? ST_DROP : ST_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else if (w_redirect) begin
            r_state    <= w_outstanding ? ST_DROP : ST_REQ;
            r_fetch_pc <= w_redirect_target;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_grant) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (w_grant) begin
                            r_req_pc   <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                            r_state    <= ST_WAIT;
                        end else if (w_buf_write) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_fetch_pc <= r_req_pc;
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    // Redirects raised during a freeze are remembered until the freeze lifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= RESET_PC;
        end else if (stop) begin
            if (branch_taken) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= branch_target;
            end
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    // Decode-facing registers: bubble on redirect, hold on stall or freeze,
    // otherwise present the held word or a bubble if none is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out.pc           <= RESET_PC;
            r_out.generate_nop <= 1'b1;
            r_instr            <= RV_NOP;
        end else if (!stop) begin
            if (w_redirect) begin
                r_out.generate_nop <= 1'b1;
                r_instr            <= RV_NOP;
            end else if (!stall) begin
                if (w_buf_valid) begin
                    r_out.pc           <= w_buf_pc;
                    r_out.generate_nop <= 1'b0;
                    r_instr            <= w_buf_instr;
                end else begin
                    r_out.generate_nop <= 1'b1;
                end
            end
        end
    end

    assign fetch_decode_buff = r_out;
    assign instr             = r_instr;

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Self-checking bench for rv32_fetch_stage: a table of per-cycle vectors for
// streaming and stall behaviour, plus directed sequences for redirects,
// freeze, mid-transaction reset, delayed grant and address wrap.
module tb_rv32_fetch_stage;
    import rv32_types::*;

    typedef struct {
        logic        stall;
        logic        expNop;
        logic [31:0] expPc;
    } vector_t;

    logic                 clk;
    logic                 reset;
    logic                 stop;
    logic                 stall;
    logic                 branch_taken;
    logic [31:0]          branch_target;
    logic                 imem_req;
    logic [31:0]          imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [31:0]          imem_rdata;
    fetch_decode_buffer_t fdb;
    rv_instr_t            instr;

    int compareCount  = 0;
    int mismatchCount = 0;

    int          memLatency = 1;
    int          gntDelay   = 0;
    int          gntLeft    = 0;
    int          memCount   = 0;
    logic        memBusy    = 1'b0;
    logic [31:0] memAddr    = 32'h0;

    logic        preReq;
    logic [31:0] preAddr;
    logic        lastHandshake;

    rv32_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .stop              (stop),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .fetch_decode_buff (fdb),
        .instr             (instr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop so the run always ends even if a sequence misbehaves.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, sample the request side before the edge, and
    // advance the memory model (one outstanding request, fixed latency, grant
    // withheld for gntDelay requesting cycles).
    task automatic applyStimulus(input logic iStall, input logic iStop, input logic iBranch,
                                 input logic [31:0] iTarget);
        logic delivered;
        logic handshake;
        stall         = iStall;
        stop          = iStop;
        branch_taken  = iBranch;
        branch_target = iTarget;
        #2;
        preReq        = imem_req;
        preAddr       = imem_addr;
        delivered     = imem_rvalid;
        handshake     = imem_req && imem_gnt;
        lastHandshake = handshake;
        @(posedge clk);
        #1;
        if (memBusy && delivered) begin
            memBusy = 1'b0;
        end else if (memBusy && memCount > 0) begin
            memCount--;
        end
        if (handshake) begin
            memBusy  = 1'b1;
            memAddr  = preAddr;
            memCount = memLatency - 1;
            gntLeft  = gntDelay;
        end else if (preReq && gntLeft > 0) begin
            gntLeft--;
        end
        imem_gnt    = (gntLeft == 0);
        imem_rvalid = memBusy && (memCount == 0);
        imem_rdata  = imem_rvalid ? memData(memAddr) : 32'hDEAD_BEEF;
        stall         = 1'b0;
        stop          = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
    endtask

    task automatic resetDut(input int latency, input int delay);
        memLatency = latency;
        gntDelay   = delay;
        reset      = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        gntLeft  = gntDelay;
        imem_gnt = (gntLeft == 0);
        reset    = 1'b0;
    endtask

    task automatic waitValid(input int budget, output logic ok, output logic [31:0] pc,
                             output logic [31:0] ins);
        ok  = 1'b0;
        pc  = 32'h0;
        ins = 32'h0;
        for (int i = 0; i < budget && !ok; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            if (fdb.generate_nop == 1'b0) begin
                ok  = 1'b1;
                pc  = fdb.pc;
                ins = instr;
            end
        end
    endtask

    task automatic waitGrant(input logic [31:0] addr, output logic found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            if (lastHandshake && preAddr == addr) found = 1'b1;
        end
    endtask

    task automatic expectValid(input string name, input logic [31:0] expPc);
        logic        ok;
        logic [31:0] pc;
        logic [31:0] ins;
        waitValid(30, ok, pc, ins);
        checkOutput({name, ".arrived"}, {31'h0, ok}, 32'h1);
        checkOutput({name, ".pc"}, pc, expPc);
        checkOutput({name, ".instr"}, ins, memData(expPc));
    endtask

    // Main test sequence.
    initial begin
        vector_t     vectors [12];
        logic        found;
        logic [31:0] holdPc;
        logic        holdNop;

        vectors[0]  = '{1'b0, 1'b1, 32'h0000_0000};
        vectors[1]  = '{1'b0, 1'b1, 32'h0000_0000};
        vectors[2]  = '{1'b0, 1'b0, 32'h0000_0000};
        vectors[3]  = '{1'b0, 1'b0, 32'h0000_0004};
        vectors[4]  = '{1'b0, 1'b0, 32'h0000_0008};
        vectors[5]  = '{1'b1, 1'b0, 32'h0000_0008};
        vectors[6]  = '{1'b1, 1'b0, 32'h0000_0008};
        vectors[7]  = '{1'b1, 1'b0, 32'h0000_0008};
        vectors[8]  = '{1'b0, 1'b0, 32'h0000_000C};
        vectors[9]  = '{1'b0, 1'b1, 32'h0000_000C};
        vectors[10] = '{1'b0, 1'b0, 32'h0000_0010};
        vectors[11] = '{1'b0, 1'b0, 32'h0000_0014};

        reset         = 1'b1;
        stop          = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'hDEAD_BEEF;

        $display("[TB] reset state and streaming with stall");
        resetDut(1, 0);
        checkOutput("reset.req", {31'h0, preReq}, 32'h0);
        checkOutput("reset.pc", fdb.pc, 32'h0);
        checkOutput("reset.nop", {31'h0, fdb.generate_nop}, 32'h1);
        checkOutput("reset.instr", instr, RV_NOP);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vectors[i].stall, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d.nop", i), {31'h0, fdb.generate_nop}, {31'h0, vectors[i].expNop});
            checkOutput($sformatf("vec%0d.pc", i), fdb.pc, vectors[i].expPc);
            if (!vectors[i].expNop) begin
                checkOutput($sformatf("vec%0d.instr", i), instr, memData(vectors[i].expPc));
            end
        end

        $display("[TB] branch while 0x10 outstanding");
        resetDut(2, 0);
        waitGrant(32'h10, found);
        checkOutput("branch.grant10", {31'h0, found}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        checkOutput("branch.bubble", {31'h0, fdb.generate_nop}, 32'h1);
        checkOutput("branch.addr", imem_addr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("branch.dropNoReq", {31'h0, preReq}, 32'h0);
        expectValid("branch.first", 32'h0000_0100);

        $display("[TB] redirect during freeze");
        resetDut(1, 0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        holdPc  = fdb.pc;
        holdNop = fdb.generate_nop;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, (k == 1 || k == 2), (k == 1) ? 32'h0000_0300 : 32'h0000_0202);
            checkOutput($sformatf("stop%0d.req", k), {31'h0, preReq}, 32'h0);
            checkOutput($sformatf("stop%0d.pc", k), fdb.pc, holdPc);
            checkOutput($sformatf("stop%0d.nop", k), {31'h0, fdb.generate_nop}, {31'h0, holdNop});
        end
        expectValid("stop.first", 32'h0000_0200);

        $display("[TB] reset with a granted request in flight");
        resetDut(2, 0);
        waitGrant(32'h8, found);
        checkOutput("midReset.grant8", {31'h0, found}, 32'h1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        checkOutput("midReset.req", {31'h0, preReq}, 32'h0);
        checkOutput("midReset.pc", fdb.pc, 32'h0);
        checkOutput("midReset.nop", {31'h0, fdb.generate_nop}, 32'h1);
        expectValid("midReset.first", 32'h0000_0000);

        $display("[TB] grant delayed four cycles");
        resetDut(1, 4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("gntWait%0d.req", k), {31'h0, preReq}, 32'h1);
            checkOutput($sformatf("gntWait%0d.addr", k), preAddr, 32'h0);
            checkOutput($sformatf("gntWait%0d.nop", k), {31'h0, fdb.generate_nop}, 32'h1);
        end
        expectValid("gntWait.first", 32'h0000_0000);

        $display("[TB] address wrap past 0xFFFFFFFC");
        resetDut(1, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        checkOutput("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        expectValid("wrap.top", 32'hFFFF_FFFC);
        expectValid("wrap.zero", 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
